// File: rtl/weight_tile_loader.sv
// Streams 3-byte weight rows from DRAM into the weight FIFO, one byte per push with a column tag.
// Define WT_LOADER_STALL_CNT_EN to build the FIFO-full stall counter; otherwise stall_cycles is tied to 0.
module weight_tile_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] base_addr,
    input  logic [7:0]  num_tiles,
    output logic        mem_rd_en,
    output logic [23:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [23:0] mem_rd_data,
    input  logic        wt_fifo_full,
    output logic        wt_fifo_wr,
    output logic [15:0] wt_fifo_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH0,
        S_PUSH1,
        S_PUSH2,
        S_DONE
    } state_t;

    state_t      state;
    logic [9:0]  rows_left;
    logic [23:0] row_q;
    logic        in_push;
    logic [1:0]  push_col;
    logic [7:0]  push_byte;

    assign in_push = (state == S_PUSH0) || (state == S_PUSH1) || (state == S_PUSH2);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        push_col  = 2'd0;
        push_byte = row_q[7:0];
        case (state)
            S_PUSH1: begin
                push_col  = 2'd1;
                push_byte = row_q[15:8];
            end
            S_PUSH2: begin
                push_col  = 2'd2;
                push_byte = row_q[23:16];
            end
            default: ;
        endcase
    end

    // The push strobe is gated by full in the same cycle, so a registered version could not honour it.
    assign wt_fifo_wr   = in_push && !wt_fifo_full;
    assign wt_fifo_data = in_push ? {6'b0, push_col, push_byte} : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_rd_en <= 1'b0;
            mem_addr  <= 24'h000000;
            rows_left <= 10'd0;
            row_q     <= 24'h000000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees this cycle's register values.
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr  <= base_addr;
                        rows_left <= {2'b00, num_tiles} * 10'd3;
                        if (num_tiles == 8'd0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_REQ;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (mem_rd_valid) begin
                        row_q <= mem_rd_data;
                        state <= S_PUSH0;
                    end
                end
                S_PUSH0: if (!wt_fifo_full) state <= S_PUSH1;
                S_PUSH1: if (!wt_fifo_full) state <= S_PUSH2;
                S_PUSH2: begin
                    if (!wt_fifo_full) begin
                        mem_addr  <= mem_addr + 24'd1;
                        rows_left <= rows_left - 10'd1;
                        if (rows_left == 10'd1) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_REQ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WT_LOADER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'h0000;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= 16'h0000;
        end else if (in_push && wt_fifo_full && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_weight_tile_loader.sv
// Scoreboard bench for weight_tile_loader: expected reads and pushes are queued at start,
// a monitor pops and compares them; DRAM and FIFO-full behaviour are modelled in the bench.
`timescale 1ns/1ps
module tb_weight_tile_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] base_addr = 24'h0;
    logic [7:0]  num_tiles = 8'h0;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic [23:0] mem_rd_data = 24'h0;
    logic        wt_fifo_full = 1'b0;
    logic        wt_fifo_wr;
    logic [15:0] wt_fifo_data;
    logic        busy;
    logic        done;
    logic [15:0] stall_cycles;

    weight_tile_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_tiles    (num_tiles),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .wt_fifo_full (wt_fifo_full),
        .wt_fifo_wr   (wt_fifo_wr),
        .wt_fifo_data (wt_fifo_data),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Scoreboard: stimulus appends, monitor consumes by index.
    logic [23:0] exp_addr[$];
    logic [15:0] exp_push[$];
    int addr_rd = 0;
    int push_rd = 0;
    int done_issued = 0;
    int done_seen = 0;
    int done_cancel = 0;
    int reads_seen = 0;
    int pushes_seen = 0;
    int outstanding = 0;

    // DRAM and FIFO-full model controls.
    logic [23:0] mem_key = 24'h0;
    int dram_lat = 1;
    int dram_cd = 0;
    logic [23:0] dram_pend_addr = 24'h0;
    bit random_full = 1'b0;
    int stall_at = 0;
    int stall_req_id = 0;
    int stall_fired_id = 0;
    int force_cnt = 0;
    bit forced_now = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mem_word(input logic [23:0] a);
        logic [23:0] p;
        p = a * 24'h9E377B;
        return p ^ mem_key;
    endfunction

    // DRAM: answers each read dram_lat cycles after the request cycle.
    always @(negedge clk) begin
        mem_rd_valid = 1'b0;
        if (dram_cd > 0) begin
            dram_cd--;
            if (dram_cd == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem_word(dram_pend_addr);
            end
        end
        if (mem_rd_en) begin
            dram_cd        = dram_lat;
            dram_pend_addr = mem_addr;
        end
    end

    // FIFO-full driver: a forced 4-cycle stall right after a chosen push, else random or clear.
    always @(negedge clk) begin
        if (stall_req_id != stall_fired_id && pushes_seen == stall_at) begin
            force_cnt      = 4;
            stall_fired_id = stall_req_id;
        end
        if (force_cnt > 0) begin
            wt_fifo_full = 1'b1;
            forced_now   = 1'b1;
            force_cnt--;
        end else begin
            forced_now   = 1'b0;
            wt_fifo_full = random_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Monitor: samples shortly before each rising edge.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            addr_rd     = exp_addr.size();
            push_rd     = exp_push.size();
            done_cancel = done_issued - done_seen;
            outstanding = 0;
        end else begin
            if (mem_rd_en) begin
                check("one_read_outstanding", outstanding, 0);
                outstanding = 1;
                reads_seen++;
                if (addr_rd < exp_addr.size()) begin
                    check("mem_addr", mem_addr, exp_addr[addr_rd]);
                    addr_rd++;
                end else begin
                    check("read_count", addr_rd + 1, exp_addr.size());
                end
            end
            if (wt_fifo_full) check("wr_while_full", wt_fifo_wr, 0);
            if (forced_now && push_rd < exp_push.size())
                check("data_held_in_stall", wt_fifo_data, exp_push[push_rd]);
            if (wt_fifo_wr && !wt_fifo_full) begin
                pushes_seen++;
                if (push_rd < exp_push.size()) begin
                    check("push_data", wt_fifo_data, exp_push[push_rd]);
                    push_rd++;
                end else begin
                    check("push_count", push_rd + 1, exp_push.size());
                end
                if (wt_fifo_data[9:8] == 2'd2) outstanding = 0;
            end
            if (done) begin
                check("done_expected", (done_issued - done_seen - done_cancel) > 0, 1);
                done_seen++;
                check("done_after_all_pushes", push_rd, exp_push.size());
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    // Queues the expected reads and pushes for a load, then pulses start for one cycle.
    task automatic issue_load(input logic [23:0] base, input logic [7:0] n);
        logic [23:0] a;
        logic [23:0] w;
        for (int r = 0; r < 3 * int'(n); r++) begin
            a = base + 24'(r);
            w = mem_word(a);
            exp_addr.push_back(a);
            exp_push.push_back({6'b0, 2'd0, w[7:0]});
            exp_push.push_back({6'b0, 2'd1, w[15:8]});
            exp_push.push_back({6'b0, 2'd2, w[23:16]});
        end
        done_issued++;
        base_addr = base;
        num_tiles = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (done_seen != prev) got = 1'b1;
        end
        check("done_within_budget", got, 1);
        check("reads_complete", addr_rd, exp_addr.size());
        check("pushes_complete", push_rd, exp_push.size());
    endtask

    task automatic run_load(input logic [23:0] base, input logic [7:0] n);
        int prev;
        prev = done_seen;
        issue_load(base, n);
        wait_done(prev, 60 * 3 * int'(n) + 20);
    endtask

    initial begin
        int prev;
        int prev_reads;
        int exp_stall;
        bit got;
        logic [23:0] b;
        logic [7:0]  n;

        mem_key = 24'($urandom());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_rd_en", mem_rd_en, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_wt_fifo_wr", wt_fifo_wr, 0);
        check("reset_wt_fifo_data", wt_fifo_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_stall_cycles", stall_cycles, 0);

        // One tile from 0x100, DRAM latency 1, no back-pressure.
        run_load(24'h000100, 8'd1);
        check("no_stalls_counted", stall_cycles, 0);

        // Zero tiles: done two cycles after start, no read, busy never high.
        prev_reads = reads_seen;
        prev = done_seen;
        issue_load(24'h123456, 8'd0);
        check("zero_done_early", done, 0);
        check("zero_busy_1", busy, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 1);
        check("zero_busy_2", busy, 0);
        @(negedge clk);
        check("zero_done_single", done, 0);
        check("zero_busy_3", busy, 0);
        check("zero_no_read", reads_seen, prev_reads);

        // Four-cycle FIFO-full stall while pushing column 1 of the first row.
`ifdef WT_LOADER_STALL_CNT_EN
        exp_stall = 4;
`else
        exp_stall = 0;
`endif
        stall_at = pushes_seen + 1;
        stall_req_id++;
        run_load(24'($urandom()), 8'd1);
        check("stall_count", stall_cycles, exp_stall);
        repeat (3) @(negedge clk);
        check("stall_count_held", stall_cycles, exp_stall);

        // Address wrap at the top of the 24-bit space; counter clears on the new start.
        run_load(24'hFFFFFF, 8'd1);
        check("stall_cleared_on_start", stall_cycles, 0);

        // A second start mid-load is ignored.
        prev = done_seen;
        prev_reads = reads_seen;
        issue_load(24'($urandom()), 8'd2);
        repeat (7) @(negedge clk);
        base_addr = 24'hABCDEF;
        num_tiles = 8'd5;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(prev, 200);
        repeat (10) @(negedge clk);
        check("restart_one_done", done_seen - prev, 1);
        check("restart_read_count", reads_seen - prev_reads, 6);

        // Reset while waiting on the second row's data, with the response arriving after reset.
        dram_lat = 3;
        prev = done_seen;
        prev_reads = reads_seen;
        issue_load(24'($urandom()), 8'd1);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (reads_seen >= prev_reads + 2) got = 1'b1;
        end
        check("reached_second_row", got, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_seen, prev);
        check("abort_busy", busy, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_rd_en", mem_rd_en, 0);
        check("abort_stall_cycles", stall_cycles, 0);
        dram_lat = 1;
        run_load(24'($urandom()), 8'd2);

        // Randomised loads with random back-pressure and DRAM latency.
        random_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dram_lat = $urandom_range(1, 3);
            b = 24'($urandom());
            n = 8'($urandom_range(0, 4));
            run_load(b, n);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        random_full = 1'b0;
        repeat (5) @(negedge clk);
        check("total_done_count", done_seen + done_cancel, done_issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
